// File: rtl/mem_port_arbiter_if.sv
// Bundle between the pipeline stages, the shared-port arbiter and the unified
// memory. The arbiter uses the slave view; the stage/memory side uses master.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        stall_if;
  logic        stall_mem;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_valid, dm_rdata, dm_valid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_valid, dm_rdata, dm_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter: serializes IF fetches and MEM loads/stores onto
// one fixed-latency memory, returns read data to the owner and drives the
// pipeline stall signals while a requester waits.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transaction; DM wins over IF, chosen access is registered out
// ISSUE | mem_en high for exactly this cycle; latency counter loaded
// WAIT  | counting memory latency down; rdata captured when cnt reaches 0
// RESP  | owner's valid pulse; nothing issues so req can drop on this edge
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Counter is loaded with MEM_LAT-1 so capture lands MEM_LAT edges after
  // the edge that samples mem_en.
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_owner_dm;
  logic        r_is_store;
  logic [3:0]  r_cnt;
  logic        r_mem_en;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        r_if_valid;
  logic        r_dm_valid;

  logic        w_issue_dm;
  logic        w_issue_if;
  logic        w_capture;
  logic        w_owner_dm_nxt;
  logic        w_is_store_nxt;
  logic [3:0]  w_cnt_nxt;
  logic        w_mem_en_nxt;
  logic        w_mem_we_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic [31:0] w_mem_wdata_nxt;
  logic [31:0] w_if_rdata_nxt;
  logic [31:0] w_dm_rdata_nxt;
  logic        w_if_valid_nxt;
  logic        w_dm_valid_nxt;
  logic        w_stall_mem;

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.dm_req || bus.if_req) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values. The memory strobe is registered on the
  // IDLE->ISSUE edge so it is high exactly during ISSUE.
  always_comb begin
    w_issue_dm      = (r_state == S_IDLE) && bus.dm_req;
    w_issue_if      = (r_state == S_IDLE) && !bus.dm_req && bus.if_req;
    w_capture       = (r_state == S_WAIT) && (r_cnt == 4'd0);

    w_owner_dm_nxt  = r_owner_dm;
    w_is_store_nxt  = r_is_store;
    w_cnt_nxt       = r_cnt;
    w_mem_en_nxt    = w_issue_dm || w_issue_if;
    w_mem_we_nxt    = w_issue_dm && bus.dm_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_rdata_nxt  = r_if_rdata;
    w_dm_rdata_nxt  = r_dm_rdata;
    w_if_valid_nxt  = w_capture && !r_owner_dm;
    w_dm_valid_nxt  = w_capture && r_owner_dm;

    if (w_issue_dm) begin
      w_owner_dm_nxt  = 1'b1;
      w_is_store_nxt  = bus.dm_we;
      w_mem_addr_nxt  = bus.dm_addr;
      w_mem_wdata_nxt = bus.dm_wdata;
    end else if (w_issue_if) begin
      w_owner_dm_nxt  = 1'b0;
      w_is_store_nxt  = 1'b0;
      w_mem_addr_nxt  = bus.if_addr;
    end

    if (r_state == S_ISSUE) begin
      w_cnt_nxt = LAT_M1;
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      w_cnt_nxt = r_cnt - 4'd1;
    end

    // A store completes with dm_valid but leaves dm_rdata untouched.
    if (w_capture) begin
      if (!r_owner_dm) begin
        w_if_rdata_nxt = bus.mem_rdata;
      end else if (!r_is_store) begin
        w_dm_rdata_nxt = bus.mem_rdata;
      end
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_dm  <= 1'b0;
      r_is_store  <= 1'b0;
      r_cnt       <= 4'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_if_rdata  <= 32'd0;
      r_dm_rdata  <= 32'd0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
    end else begin
      r_owner_dm  <= w_owner_dm_nxt;
      r_is_store  <= w_is_store_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_dm_rdata  <= w_dm_rdata_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_dm_valid  <= w_dm_valid_nxt;
    end
  end

  // Stalls are combinational so a stage freezes in the same cycle it asks,
  // and releases in the cycle its valid pulse arrives.
  assign w_stall_mem   = bus.dm_req && !r_dm_valid;
  assign bus.stall_mem = w_stall_mem;
  assign bus.stall_if  = (bus.if_req && !r_if_valid) || w_stall_mem;

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.dm_valid  = r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances (MEM_LAT = 1, 2, 3, 15) run in
// lockstep against a transaction-timeline reference model and a latency
// memory model; directed scenarios are followed by random traffic.
module tb_mem_port_arbiter;
  localparam int NI   = 4;
  localparam int MAXL = 15;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  function automatic logic [31:0] hashv(input int i, input int a);
    return (32'(a + 1) * 32'h9E37_79B1) ^ (32'(i) << 28);
  endfunction

  logic clk       = 1'b0;
  logic rst_n     = 1'b1;
  logic mem_clear = 1'b1;
  always #5 clk = ~clk;

  logic        if_req    [NI];
  logic [31:0] if_addr   [NI];
  logic        dm_req    [NI];
  logic        dm_we     [NI];
  logic [31:0] dm_addr   [NI];
  logic [31:0] dm_wdata  [NI];
  logic [31:0] mem_rdata [NI];

  logic [31:0] if_rdata_o  [NI];
  logic        if_valid_o  [NI];
  logic [31:0] dm_rdata_o  [NI];
  logic        dm_valid_o  [NI];
  logic        mem_en_o    [NI];
  logic        mem_we_o    [NI];
  logic [31:0] mem_addr_o  [NI];
  logic [31:0] mem_wdata_o [NI];
  logic        stall_if_o  [NI];
  logic        stall_mem_o [NI];

  logic [31:0] dev_mem [NI][256];
  logic [31:0] dl      [NI][MAXL];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter_if u_bus ();
    assign u_bus.if_req    = if_req[g];
    assign u_bus.if_addr   = if_addr[g];
    assign u_bus.dm_req    = dm_req[g];
    assign u_bus.dm_we     = dm_we[g];
    assign u_bus.dm_addr   = dm_addr[g];
    assign u_bus.dm_wdata  = dm_wdata[g];
    assign u_bus.mem_rdata = mem_rdata[g];
    assign if_rdata_o[g]   = u_bus.if_rdata;
    assign if_valid_o[g]   = u_bus.if_valid;
    assign dm_rdata_o[g]   = u_bus.dm_rdata;
    assign dm_valid_o[g]   = u_bus.dm_valid;
    assign mem_en_o[g]     = u_bus.mem_en;
    assign mem_we_o[g]     = u_bus.mem_we;
    assign mem_addr_o[g]   = u_bus.mem_addr;
    assign mem_wdata_o[g]  = u_bus.mem_wdata;
    assign stall_if_o[g]   = u_bus.stall_if;
    assign stall_mem_o[g]  = u_bus.stall_mem;
    assign mem_rdata[g]    = dl[g][lat_of(g) - 1];

    mem_port_arbiter #(.MEM_LAT(lat_of(g))) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_bus.slave)
    );
  end

  // Memory device: writes on the sampling edge, reads appear MEM_LAT edges
  // later; idle slots carry random garbage.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (mem_clear) begin
        for (int a = 0; a < 256; a++) dev_mem[i][a] <= hashv(i, a);
        for (int k = 0; k < MAXL; k++) dl[i][k] <= '0;
      end else begin
        if (mem_en_o[i] && mem_we_o[i]) dev_mem[i][mem_addr_o[i][9:2]] <= mem_wdata_o[i];
        for (int k = MAXL - 1; k > 0; k--) dl[i][k] <= dl[i][k-1];
        dl[i][0] <= (mem_en_o[i] && !mem_we_o[i]) ? dev_mem[i][mem_addr_o[i][9:2]] : $urandom;
      end
    end
  end

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  // reference model state
  logic [31:0] ref_mem [NI][256];
  bit          tx_act   [NI];
  int          tx_start [NI];
  bit          tx_dm    [NI];
  bit          tx_we    [NI];
  logic [31:0] tx_addr  [NI];
  logic [31:0] tx_wdata [NI];
  logic [31:0] tx_rval  [NI];
  logic [31:0] e_maddr  [NI];
  logic [31:0] e_mwdata [NI];
  logic [31:0] e_ifrd   [NI];
  logic [31:0] e_dmrd   [NI];

  // requester / stimulus state
  bit          seen_ifv [NI];
  bit          seen_dmv [NI];
  bit          frc_if   [NI];
  bit          frc_dm   [NI];
  logic [31:0] f_if_addr, f_dm_addr, f_dm_wdata;
  bit          f_dm_we;

  // per-phase observations
  int ifv_cyc [NI], dmv_cyc [NI], ifv_n [NI], dmv_n [NI], men_n [NI];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic string tg(input int i, input string s);
    return $sformatf("lat%0d_%s", lat_of(i), s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      tx_act[i]   = 1'b0;
      e_maddr[i]  = '0;
      e_mwdata[i] = '0;
      e_ifrd[i]   = '0;
      e_dmrd[i]   = '0;
    end
  endtask

  task automatic start_tx(input int i, input bit dm);
    tx_act[i]   = 1'b1;
    tx_start[i] = cyc;
    tx_dm[i]    = dm;
    if (dm) begin
      tx_we[i]    = dm_we[i];
      tx_addr[i]  = dm_addr[i];
      tx_wdata[i] = dm_wdata[i];
      tx_rval[i]  = ref_mem[i][dm_addr[i][9:2]];
      if (dm_we[i]) ref_mem[i][dm_addr[i][9:2]] = dm_wdata[i];
    end else begin
      tx_we[i]   = 1'b0;
      tx_addr[i] = if_addr[i];
      tx_rval[i] = ref_mem[i][if_addr[i][9:2]];
    end
  endtask

  // Timeline model: a transaction started in idle cycle S shows mem_en in
  // S+1, its valid pulse in S+L+2, and the port is idle again at S+L+3.
  task automatic model_step(input int i);
    int L;
    bit e_men, e_ifv, e_dmv, e_sm;
    L     = lat_of(i);
    e_men = tx_act[i] && (cyc == tx_start[i] + 1);
    e_ifv = tx_act[i] && !tx_dm[i] && (cyc == tx_start[i] + L + 2);
    e_dmv = tx_act[i] &&  tx_dm[i] && (cyc == tx_start[i] + L + 2);
    if (e_men) begin
      e_maddr[i] = tx_addr[i];
      if (tx_dm[i]) e_mwdata[i] = tx_wdata[i];
    end
    if (e_ifv) e_ifrd[i] = tx_rval[i];
    if (e_dmv && !tx_we[i]) e_dmrd[i] = tx_rval[i];
    e_sm = dm_req[i] && !e_dmv;
    chk(tg(i, "mem_en"),    32'(mem_en_o[i]),   32'(e_men));
    chk(tg(i, "mem_we"),    32'(mem_we_o[i]),   32'(e_men && tx_we[i]));
    chk(tg(i, "mem_addr"),  mem_addr_o[i],      e_maddr[i]);
    chk(tg(i, "mem_wdata"), mem_wdata_o[i],     e_mwdata[i]);
    chk(tg(i, "if_valid"),  32'(if_valid_o[i]), 32'(e_ifv));
    chk(tg(i, "dm_valid"),  32'(dm_valid_o[i]), 32'(e_dmv));
    chk(tg(i, "if_rdata"),  if_rdata_o[i],      e_ifrd[i]);
    chk(tg(i, "dm_rdata"),  dm_rdata_o[i],      e_dmrd[i]);
    chk(tg(i, "stall_mem"), 32'(stall_mem_o[i]), 32'(e_sm));
    chk(tg(i, "stall_if"),  32'(stall_if_o[i]),  32'((if_req[i] && !e_ifv) || e_sm));
    if (!tx_act[i] || (cyc >= tx_start[i] + L + 3)) begin
      if (dm_req[i])      start_tx(i, 1'b1);
      else if (if_req[i]) start_tx(i, 1'b0);
    end
  endtask

  task automatic drive(input int i, input bit rnd);
    if (if_req[i] && seen_ifv[i]) if_req[i] = 1'b0;
    if (dm_req[i] && seen_dmv[i]) dm_req[i] = 1'b0;
    if (frc_if[i]) begin
      if_req[i]  = 1'b1;
      if_addr[i] = f_if_addr;
      frc_if[i]  = 1'b0;
    end else if (rnd && !if_req[i] && ($urandom_range(0, 2) == 0)) begin
      if_req[i]  = 1'b1;
      if_addr[i] = {22'd0, 8'($urandom), 2'b00};
    end
    if (frc_dm[i]) begin
      dm_req[i]   = 1'b1;
      dm_we[i]    = f_dm_we;
      dm_addr[i]  = f_dm_addr;
      dm_wdata[i] = f_dm_wdata;
      frc_dm[i]   = 1'b0;
    end else if (rnd && !dm_req[i] && ($urandom_range(0, 2) == 0)) begin
      dm_req[i]   = 1'b1;
      dm_we[i]    = 1'($urandom_range(0, 1));
      dm_addr[i]  = {22'd0, 8'($urandom), 2'b00};
      dm_wdata[i] = $urandom;
    end
  endtask

  task automatic run_cycle(input bit rnd);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) drive(i, rnd);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      model_step(i);
      seen_ifv[i] = if_valid_o[i];
      seen_dmv[i] = dm_valid_o[i];
      if (if_valid_o[i]) begin ifv_cyc[i] = cyc; ifv_n[i]++; end
      if (dm_valid_o[i]) begin dmv_cyc[i] = cyc; dmv_n[i]++; end
      if (mem_en_o[i]) men_n[i]++;
    end
    cyc++;
  endtask

  task automatic clr_track();
    for (int i = 0; i < NI; i++) begin
      ifv_cyc[i] = -1; dmv_cyc[i] = -1;
      ifv_n[i] = 0; dmv_n[i] = 0; men_n[i] = 0;
    end
  endtask

  task automatic force_all(input bit do_if, input logic [31:0] ia, input bit do_dm,
                           input bit we, input logic [31:0] da, input logic [31:0] wd);
    f_if_addr  = ia;
    f_dm_we    = we;
    f_dm_addr  = da;
    f_dm_wdata = wd;
    for (int i = 0; i < NI; i++) begin
      frc_if[i] = do_if;
      frc_dm[i] = do_dm;
    end
  endtask

  task automatic check_reset(input string s);
    for (int i = 0; i < NI; i++) begin
      chk(tg(i, {s, "_mem_en"}),    32'(mem_en_o[i]),    32'd0);
      chk(tg(i, {s, "_mem_we"}),    32'(mem_we_o[i]),    32'd0);
      chk(tg(i, {s, "_mem_addr"}),  mem_addr_o[i],       32'd0);
      chk(tg(i, {s, "_mem_wdata"}), mem_wdata_o[i],      32'd0);
      chk(tg(i, {s, "_if_rdata"}),  if_rdata_o[i],       32'd0);
      chk(tg(i, {s, "_dm_rdata"}),  dm_rdata_o[i],       32'd0);
      chk(tg(i, {s, "_if_valid"}),  32'(if_valid_o[i]),  32'd0);
      chk(tg(i, {s, "_dm_valid"}),  32'(dm_valid_o[i]),  32'd0);
      chk(tg(i, {s, "_stall_if"}),  32'(stall_if_o[i]),  32'd0);
      chk(tg(i, {s, "_stall_mem"}), 32'(stall_mem_o[i]), 32'd0);
    end
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      if_req[i] = 1'b0; dm_req[i] = 1'b0;
      frc_if[i] = 1'b0; frc_dm[i] = 1'b0;
      seen_ifv[i] = 1'b0; seen_dmv[i] = 1'b0;
    end
    #1;
    check_reset("rst_async");
    @(posedge clk);
    #1;
    check_reset("rst_hold");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int t0;
    int L;
    for (int i = 0; i < NI; i++) begin
      if_req[i] = 1'b0; if_addr[i] = '0;
      dm_req[i] = 1'b0; dm_we[i] = 1'b0; dm_addr[i] = '0; dm_wdata[i] = '0;
      seen_ifv[i] = 1'b0; seen_dmv[i] = 1'b0;
      frc_if[i] = 1'b0; frc_dm[i] = 1'b0;
      for (int a = 0; a < 256; a++) ref_mem[i][a] = hashv(i, a);
    end
    model_reset();
    clr_track();

    #2 rst_n = 1'b0;
    #1 check_reset("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_clear = 1'b0;

    // Contention: store to 0x40 and fetch of 0x40 in the same cycle.
    clr_track();
    t0 = cyc;
    force_all(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 32'h2008_0005);
    repeat (40) run_cycle(1'b0);
    for (int i = 0; i < NI; i++) begin
      L = lat_of(i);
      chk(tg(i, "A_dm_lat"),   32'(dmv_cyc[i] - t0), 32'(L + 2));
      chk(tg(i, "A_if_lat"),   32'(ifv_cyc[i] - t0), 32'(2 * L + 5));
      chk(tg(i, "A_mem_en_n"), 32'(men_n[i]),        32'd2);
      chk(tg(i, "A_if_rdata"), if_rdata_o[i],        32'h2008_0005);
      chk(tg(i, "A_dm_rdata"), dm_rdata_o[i],        32'd0);
    end

    // Store then load at 0x100.
    clr_track();
    force_all(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    repeat (20) run_cycle(1'b0);
    for (int i = 0; i < NI; i++) begin
      chk(tg(i, "B_store_valid_n"), 32'(dmv_n[i]), 32'd1);
      chk(tg(i, "B_store_rdata"),   dm_rdata_o[i],  32'd0);
    end
    t0 = cyc;
    force_all(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
    repeat (20) run_cycle(1'b0);
    for (int i = 0; i < NI; i++) begin
      L = lat_of(i);
      chk(tg(i, "B_load_lat"),   32'(dmv_cyc[i] - t0), 32'(L + 2));
      chk(tg(i, "B_load_rdata"), dm_rdata_o[i],        32'hDEAD_BEEF);
      chk(tg(i, "B_valid_n"),    32'(dmv_n[i]),        32'd2);
      chk(tg(i, "B_mem_en_n"),   32'(men_n[i]),        32'd2);
    end

    // Single fetch.
    clr_track();
    t0 = cyc;
    force_all(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (20) run_cycle(1'b0);
    for (int i = 0; i < NI; i++) begin
      L = lat_of(i);
      chk(tg(i, "C_if_lat"),   32'(ifv_cyc[i] - t0), 32'(L + 2));
      chk(tg(i, "C_if_rdata"), if_rdata_o[i],        32'hDEAD_BEEF);
      chk(tg(i, "C_mem_en_n"), 32'(men_n[i]),        32'd1);
    end

    // Reset while the MEM_LAT=3 instance is in WAIT.
    force_all(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) run_cycle(1'b0);
    do_reset();
    clr_track();
    repeat (20) run_cycle(1'b0);
    for (int i = 0; i < NI; i++) begin
      chk(tg(i, "D_if_valid_n"), 32'(ifv_n[i]), 32'd0);
      chk(tg(i, "D_dm_valid_n"), 32'(dmv_n[i]), 32'd0);
      chk(tg(i, "D_mem_en_n"),   32'(men_n[i]), 32'd0);
    end

    // Random traffic.
    repeat (800) run_cycle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the CPU's single shared memory port. It serializes instruction fetches from the IF stage and data loads/stores from the MEM stage onto one fixed-latency memory, returning the fetched words to each requester. While a requester waits, it generates the stall signals that freeze the IF/ID and MEM/WB pipeline registers. It sits between the pipeline stages and the unified memory.

## Interface
Parameters:
- MEM_LAT, 1, memory read latency in cycles, counted from the edge that samples mem_en=1 to the edge that samples valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  32  fetch address; stable while if_req is high
- if_rdata  out  32  fetched instruction; valid when if_valid is high, held afterwards
- if_valid  out  1  one-cycle fetch-complete pulse
- dm_req  in  1  data request; held high until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data; valid when dm_valid is high, held afterwards
- dm_valid  out  1  one-cycle data-complete pulse (load or store)
- mem_en  out  1  memory access strobe, exactly one cycle per transaction
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- stall_if  out  1  freezes the PC and IF/ID
- stall_mem  out  1  freezes EX/MEM and holds MEM/WB

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. A register `owner` (IF or DM) records the current transaction.
- IDLE: if dm_req, then owner=DM, go to ISSUE. Else if if_req, then owner=IF, go to ISSUE. Else stay. Data has fixed priority over fetch.
- ISSUE (one cycle): mem_en=1. Load mem_addr from the owner's address. For owner DM, mem_we=dm_we and mem_wdata=dm_wdata; for owner IF, mem_we=0. Load cnt=MEM_LAT-1, go to WAIT. mem_en, mem_we, mem_addr and mem_wdata are registered outputs.
- WAIT: if cnt==0, capture mem_rdata into the owner's rdata register and go to RESP; otherwise decrement cnt. On a store, dm_rdata is not updated.
- RESP (one cycle): assert the owner's valid, then return to IDLE. No new transaction may issue in RESP. This lets the requester drop its req on the same edge without a duplicate issue.
- Stall outputs are combinational:
  - stall_mem = dm_req & ~dm_valid
  - stall_if = (if_req & ~if_valid) | stall_mem
- mem_addr and mem_wdata hold their last values when mem_en=0. mem_we=0 whenever mem_en=0.
- cnt is 4 bits wide.

## Timing
- Reset (async assert, whole block): state=IDLE, owner=IF, cnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_valid=0, dm_valid=0. Any in-flight transaction is abandoned, and later mem_rdata is ignored.
- Latency: a request first seen in IDLE in cycle T produces:
  - mem_en high in cycle T+1
  - capture at the end of cycle T+1+MEM_LAT
  - valid pulse in cycle T+2+MEM_LAT
- Per-transaction occupancy is MEM_LAT+3 cycles including IDLE. Back-to-back requests therefore start every MEM_LAT+3 cycles.
- Simultaneous if_req and dm_req in IDLE: DM is served first, and IF is served in the following IDLE if dm_req is low there.
- A request arriving while busy waits; it is never dropped.
- A request deasserted mid-transaction (pipeline flush) does not abort the transaction. The valid pulse still occurs and is ignored by the stage.
- A fetch can starve only while dm_req stays continuously high.

## Test plan
- Reset mid-WAIT: with MEM_LAT=3, assert rst_n=0 during WAIT -> all outputs are at reset values immediately; after release, the state is IDLE and no valid pulse occurs.
- Single fetch: MEM_LAT=2, if_addr=0x0000_0040, memory returns 0x2008_0005 -> mem_en pulses in T+1 with addr 0x40 and mem_we=0. if_valid is high for one cycle at T+4 with if_rdata=0x2008_0005. stall_if is high in T..T+3 and low at T+4.
- Store then load: dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF, then dm_we=0 at the same address -> the first mem_en has mem_we=1 and wdata 0xDEADBEEF. dm_valid pulses twice. The second dm_rdata is 0xDEADBEEF and dm_rdata is unchanged after the store.
- Contention: if_req and dm_req rise in the same cycle, MEM_LAT=1 -> DM issues in T+1 and dm_valid occurs at T+3. IF issues at T+5 and if_valid occurs at T+7. stall_if stays high until T+7, and stall_mem drops at T+3.
- Latency sweep: MEM_LAT=1 and MEM_LAT=15, one load each -> the valid pulse occurs at T+3 and T+17 respectively, with exactly one mem_en pulse per transaction.
